// File: rtl/bsg_counter_sample_sched_pkg.sv
// Shared types and default sizing for the counter sample scheduler.
package bsg_counter_sample_sched_pkg;

   // Scheduler states: waiting for a window to close, or streaming snapshot beats
   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } sched_state_e;

   localparam int els_default_lp    = 4;
   localparam int width_default_lp  = 7;
   localparam int window_default_lp = 64;

endpackage

// File: rtl/bsg_counter_clear_up_sat.sv
// Clear/up counter that saturates at all-ones and keeps a sticky flag
// recording any increment that was attempted while already at the maximum.
module bsg_counter_clear_up_sat
   import bsg_counter_sample_sched_pkg::*;
#(
   parameter int width_p = width_default_lp
)(
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               clear_i,
   input  logic               up_i,
   output logic [width_p-1:0] count_o,
   output logic               sat_o
);

   localparam logic [width_p-1:0] max_lp = '1;

   logic [width_p-1:0] base;
   logic               at_max;

   // Increment that refuses to wrap past the maximum
   function automatic logic [width_p-1:0] sat_inc(input logic [width_p-1:0] v,
                                                  input logic               up);
      if (up && (v != max_lp)) return v + width_p'(1);
      return v;
   endfunction

   // A clear restarts from zero, so a same-cycle increment lands as the first count
   assign base   = clear_i ? '0 : count_o;
   assign at_max = (base == max_lp);

   // Count and sticky saturation update; clear drops the flag along with the count
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         count_o <= '0;
         sat_o   <= 1'b0;
      end else begin
         count_o <= sat_inc(base, up_i);
         sat_o   <= (clear_i ? 1'b0 : sat_o) | (up_i & at_max);
      end
   end

endmodule

// File: rtl/bsg_counter_sample_sched.sv
// Per-source event counters sampled at the end of each enabled window (or on
// flush), then streamed out one source per beat over a valid/ready port.
module bsg_counter_sample_sched
   import bsg_counter_sample_sched_pkg::*;
#(
   parameter int els_p    = els_default_lp,
   parameter int width_p  = width_default_lp,
   parameter int window_p = window_default_lp,
   localparam int id_w_lp    = (els_p > 1) ? $clog2(els_p) : 1,
   localparam int timer_w_lp = $clog2(window_p)
)(
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               en_i,
   input  logic               flush_i,
   input  logic [els_p-1:0]   event_i,
   output logic               v_o,
   input  logic               ready_i,
   output logic [id_w_lp-1:0] id_o,
   output logic [width_p-1:0] count_o,
   output logic               sat_o
);

   localparam logic [timer_w_lp-1:0] timer_last_lp = timer_w_lp'(window_p - 1);
   localparam logic [id_w_lp-1:0]    idx_last_lp   = id_w_lp'(els_p - 1);

   sched_state_e          state;
   logic [timer_w_lp-1:0] timer;
   logic [id_w_lp-1:0]    idx;
   logic                  snapshot;

   logic [width_p-1:0] cnt      [els_p];
   logic               cnt_sat  [els_p];
   logic [width_p-1:0] snap_cnt [els_p];
   logic               snap_sat [els_p];

   // Snapshots are only taken while idle; an expiry during a drain waits with
   // the timer parked at its last value, while a flush during a drain is dropped.
   assign snapshot = (state == IDLE) &&
                     ((en_i && (timer == timer_last_lp)) || flush_i);

   // The snapshot cycle doubles as the clear, so that cycle's events open the next window
   for (genvar g = 0; g < els_p; g++) begin : g_cnt
      bsg_counter_clear_up_sat #(
         .width_p (width_p)
      ) u_cnt (
         .clk_i     (clk_i),
         .reset_n_i (reset_n_i),
         .clear_i   (snapshot),
         .up_i      (event_i[g]),
         .count_o   (cnt[g]),
         .sat_o     (cnt_sat[g])
      );
   end

   // Capture every counter and its sticky flag on the snapshot cycle
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < els_p; i++) begin
            snap_cnt[i] <= '0;
            snap_sat[i] <= 1'b0;
         end
      end else if (snapshot) begin
         for (int i = 0; i < els_p; i++) begin
            snap_cnt[i] <= cnt[i];
            snap_sat[i] <= cnt_sat[i];
         end
      end
   end

   // Scheduler: window timer plus IDLE/DRAIN sequencing of the beat index
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state <= IDLE;
         timer <= '0;
         idx   <= '0;
      end else begin
         if (snapshot)
            timer <= '0;
         else if (en_i && (timer != timer_last_lp))
            timer <= timer + timer_w_lp'(1);

         if (state == IDLE) begin
            if (snapshot) begin
               state <= DRAIN;
               idx   <= '0;
            end
         end else if (ready_i) begin
            if (idx == idx_last_lp) begin
               state <= IDLE;
               idx   <= '0;
            end else begin
               idx <= idx + id_w_lp'(1);
            end
         end
      end
   end

   // Beat outputs come straight from registers and read as zero while idle
   assign v_o     = (state == DRAIN);
   assign id_o    = v_o ? idx : '0;
   assign count_o = v_o ? snap_cnt[idx] : '0;
   assign sat_o   = v_o & snap_sat[idx];

endmodule

// File: tb/tb_bsg_counter_sample_sched.sv
// Randomized and directed bench for bsg_counter_sample_sched with a
// queue-based scoreboard fed by an event-count reference model.
module tb_bsg_counter_sample_sched;

   localparam int ELS  = 4;
   localparam int W    = 7;
   localparam int WIN  = 8;
   localparam int MAXC = (1 << W) - 1;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           en;
   logic           flush;
   logic           ready;
   logic [ELS-1:0] ev;
   logic           v;
   logic [1:0]     id;
   logic [W-1:0]   cnt;
   logic           sat;

   bsg_counter_sample_sched #(
      .els_p    (ELS),
      .width_p  (W),
      .window_p (WIN)
   ) dut (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .en_i      (en),
      .flush_i   (flush),
      .event_i   (ev),
      .v_o       (v),
      .ready_i   (ready),
      .id_o      (id),
      .count_o   (cnt),
      .sat_o     (sat)
   );

   always #5 clk = ~clk;

   typedef struct {
      int id;
      int cnt;
      bit sat;
   } beat_t;

   beat_t exp_q[$];
   int    tests = 0;
   int    fails = 0;
   bit    mon_on = 1'b0;

   // Reference state: raw events per source since the last snapshot,
   // enabled cycles since the last snapshot, beats still owed to the consumer.
   int m_n [ELS];
   int m_en_cnt;
   int m_beats;
   int last_cnt [ELS];
   int last_sat [ELS];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model, evaluated on the same edge the design samples its inputs
   always @(posedge clk) begin
      bit snap;
      if (reset_n !== 1'b1) begin
         for (int i = 0; i < ELS; i++) m_n[i] = 0;
         m_en_cnt = 0;
         m_beats  = 0;
         exp_q.delete();
      end else begin
         snap = (m_beats == 0) && ((en && m_en_cnt == WIN - 1) || flush);
         if (m_beats > 0 && ready) m_beats--;
         if (snap) begin
            for (int i = 0; i < ELS; i++) begin
               exp_q.push_back('{id: i,
                                 cnt: (m_n[i] > MAXC) ? MAXC : m_n[i],
                                 sat: (m_n[i] > MAXC)});
               m_n[i] = int'(ev[i]);
            end
            m_en_cnt = 0;
            m_beats  = ELS;
         end else begin
            for (int i = 0; i < ELS; i++) m_n[i] += int'(ev[i]);
            if (en && m_en_cnt < WIN - 1) m_en_cnt++;
         end
      end
   end

   // Monitor: checks valid timing, beat contents on acceptance, stall stability
   int h_id, h_cnt, h_sat;
   bit held = 1'b0;
   always @(negedge clk) begin
      beat_t e;
      if (mon_on) begin
         check("v_o", int'(v), int'(m_beats > 0));
         if (v === 1'b1) begin
            if (held) begin
               check("stall_id", int'(id), h_id);
               check("stall_count", int'(cnt), h_cnt);
               check("stall_sat", int'(sat), h_sat);
            end
            if (ready === 1'b1) begin
               held = 1'b0;
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL beat_unexpected: got id %0d count %0d with none expected", id, cnt);
               end else begin
                  e = exp_q.pop_front();
                  check("beat_id", int'(id), e.id);
                  check("beat_count", int'(cnt), e.cnt);
                  check("beat_sat", int'(sat), int'(e.sat));
                  last_cnt[e.id] = int'(cnt);
                  last_sat[e.id] = int'(sat);
               end
            end else begin
               held  = 1'b1;
               h_id  = int'(id);
               h_cnt = int'(cnt);
               h_sat = int'(sat);
            end
         end else begin
            held = 1'b0;
            check("idle_id", int'(id), 0);
            check("idle_count", int'(cnt), 0);
            check("idle_sat", int'(sat), 0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_v(input int lim);
      int k = 0;
      while (v !== 1'b1 && k < lim) begin
         step();
         k++;
      end
      if (v !== 1'b1) begin
         tests++;
         fails++;
         $display("FAIL wait_valid: got v_o=%b expected 1 within %0d cycles", v, lim);
      end
   endtask

   task automatic wait_idle(input int lim);
      int k = 0;
      while (v === 1'b1 && k < lim) begin
         step();
         k++;
      end
      if (v === 1'b1) begin
         tests++;
         fails++;
         $display("FAIL wait_idle: got v_o=%b expected 0 within %0d cycles", v, lim);
      end
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0;
      en      = 1'b0;
      flush   = 1'b0;
      ready   = 1'b1;
      ev      = '0;
      step();
      mon_on  = 1'b1;
      step();
      step();
      check("reset_v", int'(v), 0);
      check("reset_id", int'(id), 0);
      check("reset_count", int'(cnt), 0);
      check("reset_sat", int'(sat), 0);

      // Steady windows with source 0 firing every cycle
      reset_n = 1'b1;
      en      = 1'b1;
      ev      = 4'b0001;
      repeat (40) step();
      check("win_id0", last_cnt[0], 8);
      check("win_id1", last_cnt[1], 0);
      check("win_sat0", last_sat[0], 0);

      // Consumer stalls 20 cycles; expiry is deferred until the drain ends
      wait_idle(20);
      ev    = 4'b0010;
      ready = 1'b0;
      wait_v(20);
      repeat (20) step();
      ready = 1'b1;
      wait_idle(20);
      wait_v(20);
      wait_idle(20);

      // Flush with the timer frozen; a second flush mid-drain is dropped
      en = 1'b0;
      ev = '0;
      wait_idle(20);
      ev = 4'b1000;
      repeat (3) step();
      ev = '0;
      pulse_flush();
      pulse_flush();
      wait_idle(20);
      repeat (3) step();
      check("flush_id3", last_cnt[3], 3);
      check("flush_ignored_q", exp_q.size(), 0);

      // Saturation on source 2, twice, then a short window showing the flag cleared
      for (int r = 0; r < 2; r++) begin
         ev = 4'b0100;
         repeat (200) step();
         ev = '0;
         pulse_flush();
         wait_idle(20);
         check("sat_count", last_cnt[2], MAXC);
         check("sat_flag", last_sat[2], 1);
      end
      ev = 4'b0100;
      repeat (3) step();
      ev = '0;
      pulse_flush();
      wait_idle(20);
      check("post_sat_count", last_cnt[2], 3);
      check("post_sat_flag", last_sat[2], 0);

      // Event on the snapshot cycle belongs to the next window
      ev = 4'b0001;
      flush = 1'b1;
      step();
      ev = '0;
      flush = 1'b0;
      wait_idle(20);
      check("edge_excl_id0", last_cnt[0], 0);
      pulse_flush();
      wait_idle(20);
      check("edge_next_id0", last_cnt[0], 1);

      // Reset while the id2 beat is stalled
      ready = 1'b0;
      pulse_flush();
      ready = 1'b1;
      step();
      step();
      ready = 1'b0;
      check("pre_reset_id", int'(id), 2);
      reset_n = 1'b0;
      step();
      check("rst_drain_v", int'(v), 0);
      check("rst_drain_count", int'(cnt), 0);
      reset_n = 1'b1;
      ready   = 1'b1;
      ev      = 4'b0001;
      repeat (5) step();
      ev = '0;
      pulse_flush();
      wait_idle(20);
      check("post_reset_id0", last_cnt[0], 5);
      check("post_reset_id2", last_cnt[2], 0);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         en      = ($urandom % 8) != 0;
         flush   = ($urandom % 40) == 0;
         ev      = ELS'($urandom);
         ready   = ($urandom % 4) != 0;
         reset_n = ($urandom % 1000) != 0;
         step();
      end

      reset_n = 1'b1;
      en      = 1'b0;
      flush   = 1'b0;
      ev      = '0;
      ready   = 1'b1;
      wait_idle(50);
      repeat (3) step();
      check("final_queue", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
